// File: rtl/rgb_seq_ctrl_if.sv
// ============================================================================
// Module      : rgb_seq_ctrl_if
// Description : Control/status bundle between a colour-sequence driver and
//               rgb_seq_ctrl. Carries `dir` only when SEQ_REVERSE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rgb_seq_ctrl_if;
    logic       en;
    logic       mode;
    logic       step;
    logic       hold;
`ifdef SEQ_REVERSE_EN
    logic       dir;
`endif
    logic [2:0] state;
    logic [7:0] pwm_cnt;
    logic       period_start;
    logic       state_changed;

`ifdef SEQ_REVERSE_EN
    modport master (
        output en, mode, step, hold, dir,
        input  state, pwm_cnt, period_start, state_changed
    );
    modport slave (
        input  en, mode, step, hold, dir,
        output state, pwm_cnt, period_start, state_changed
    );
`else
    modport master (
        output en, mode, step, hold,
        input  state, pwm_cnt, period_start, state_changed
    );
    modport slave (
        input  en, mode, step, hold,
        output state, pwm_cnt, period_start, state_changed
    );
`endif
endinterface

`default_nettype wire

// File: rtl/rgb_seq_ctrl.sv
// ============================================================================
// Module      : rgb_seq_ctrl
// Description : RGB PWM sequencer - period counter plus colour-state stepping
//               (auto dwell or manual step), updated only on period boundaries.
//               Optional macro SEQ_REVERSE_EN adds a `dir` input for reverse stepping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb_seq_ctrl #(
    parameter int CLK_DIV       = 100,
    parameter int DWELL_PERIODS = 256,
    parameter int NUM_STATES    = 6
) (
    input  wire logic     clk,
    input  wire logic     rst,
    rgb_seq_ctrl_if.slave io_seq
);

    localparam int       c_PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int       c_DWELL_W = (DWELL_PERIODS > 1) ? $clog2(DWELL_PERIODS) : 1;
    localparam bit [2:0] c_LAST    = 3'(NUM_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } fsm_t;

    fsm_t                 r_fsm;
    logic [c_PRESC_W-1:0] r_presc;
    logic [7:0]           r_pwm;
    logic [c_DWELL_W-1:0] r_dwell;
    logic [2:0]           r_state;
    logic                 r_period_start;
    logic                 r_state_changed;
    logic                 r_mode_q;

    logic       w_tick;
    logic       w_boundary;
    logic       w_mode_chg;
    logic       w_step_acc;
    logic       w_dwell_done;
    logic       w_advance;
    logic [2:0] w_next_state;

    assign w_tick       = (r_presc == c_PRESC_W'(CLK_DIV - 1));
    assign w_boundary   = w_tick && (r_pwm == 8'hFF);
    assign w_mode_chg   = (io_seq.mode != r_mode_q);
    assign w_step_acc   = io_seq.step && !io_seq.hold && !w_mode_chg;
    assign w_dwell_done = io_seq.mode && (r_dwell == c_DWELL_W'(DWELL_PERIODS - 1));
    // A pending step and a dwell expiry on the same boundary yield a single advance.
    assign w_advance    = w_boundary && !io_seq.hold && !w_mode_chg &&
                          ((r_fsm == S_PEND) || w_dwell_done);

    always_comb begin
        w_next_state = (r_state == c_LAST) ? 3'd0 : r_state + 3'd1;
`ifdef SEQ_REVERSE_EN
        if (io_seq.dir) begin
            w_next_state = (r_state == 3'd0) ? c_LAST : r_state - 3'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        // Tracked through reset so the first cycle after release is not seen as a mode change.
        r_mode_q <= io_seq.mode;
        if (rst) begin
            r_fsm           <= S_IDLE;
            r_presc         <= '0;
            r_pwm           <= '0;
            r_dwell         <= '0;
            r_state         <= '0;
            r_period_start  <= 1'b0;
            r_state_changed <= 1'b0;
        end else if (!io_seq.en) begin
            r_fsm           <= S_IDLE;
            r_presc         <= '0;
            r_pwm           <= '0;
            r_dwell         <= '0;
            r_period_start  <= 1'b0;
            r_state_changed <= 1'b0;
        end else begin
            r_presc         <= w_tick ? '0 : r_presc + c_PRESC_W'(1);
            if (w_tick) begin
                r_pwm <= r_pwm + 8'd1;
            end
            r_period_start  <= w_boundary;
            r_state_changed <= w_advance;
            if (w_advance) begin
                r_state <= w_next_state;
            end

            if (w_mode_chg || !io_seq.mode || w_advance) begin
                r_dwell <= '0;
            end else if (w_boundary && !io_seq.hold) begin
                r_dwell <= r_dwell + c_DWELL_W'(1);
            end

            // A step arriving on the consuming boundary re-arms PEND for the next one.
            case (r_fsm)
                S_IDLE:  r_fsm <= w_step_acc ? S_PEND : S_RUN;
                S_RUN:   if (w_step_acc) r_fsm <= S_PEND;
                S_PEND: begin
                    if (w_mode_chg) begin
                        r_fsm <= S_RUN;
                    end else if (w_advance) begin
                        r_fsm <= w_step_acc ? S_PEND : S_RUN;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign io_seq.state         = r_state;
    assign io_seq.pwm_cnt       = r_pwm;
    assign io_seq.period_start  = r_period_start;
    assign io_seq.state_changed = r_state_changed;

endmodule

`default_nettype wire

// File: doc/rgb_seq_ctrl.md
Name: rgb_seq_ctrl

Overview:
- Sequencer for the RGB PWM colour decoder.
- Generates the shared 8-bit PWM period counter and drives the 3-bit colour `state` (0..5) that the decoder maps to R/G/B duty values.
- Two modes: auto-cycle after a programmable dwell, or manual step on a button pulse.
- `state` changes only on a PWM period boundary, so no partial-period colour glitches.

Parameters:
- CLK_DIV, 100, clk cycles per PWM count step (>=1).
- DWELL_PERIODS, 256, PWM periods spent on each colour in auto mode (>=1).
- NUM_STATES, 6, number of colour states; `state` wraps NUM_STATES-1 -> 0.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable.
- mode  in  1  0 = manual, 1 = auto.
- step  in  1  single-cycle advance request (debounced upstream).
- hold  in  1  freeze state advance; counters keep running.
- state  out  3  colour index to the decoder.
- pwm_cnt  out  8  PWM compare counter, shared by R/G/B comparators.
- period_start  out  1  high for one cycle when pwm_cnt has just wrapped to 0.
- state_changed  out  1  high for one cycle in the first cycle `state` shows its new value.

Behaviour:
- Reset: one clk with rst=1 takes effect at the next edge.
  - All outputs cleared: state=0, pwm_cnt=0, period_start=0, state_changed=0.
  - Internals cleared: prescaler=0, dwell=0, pending=0.
  - FSM goes to IDLE.
  - rst mid-operation aborts any pending step.
- Prescaler: counts 0..CLK_DIV-1 while en=1. `tick` = prescaler==CLK_DIV-1; prescaler then returns to 0.
- pwm_cnt: +1 on each tick; 255 -> 0 wrap.
- Boundary: the edge where tick && pwm_cnt==255.
  - At this edge pwm_cnt goes to 0 and period_start is registered 1.
  - Any state update happens on this same edge, so new state, pwm_cnt=0 and period_start are coincident.
- FSM states:
  - IDLE: en=0. Prescaler, pwm_cnt, dwell and pending are cleared; state is retained; period_start=0. Goes to RUN when en=1.
  - RUN: counters run. Goes to PEND on a step accept. Goes to IDLE when en=0.
  - PEND: step latched, waiting for the boundary. At the boundary: advance, then RUN. Goes to IDLE when en=0, discarding the step.
- Advance: state = (state==NUM_STATES-1) ? 0 : state+1. state_changed=1 for the following cycle.
- Auto mode (mode=1, hold=0):
  - dwell increments at each boundary.
  - When dwell==DWELL_PERIODS-1 at a boundary: advance, dwell->0.
- Manual mode (mode=0): dwell held at 0. Advance only via PEND.
- Step accept:
  - step=1 while en=1 and hold=0 sets pending. Multiple steps before a boundary collapse into one advance.
  - step in auto mode is also honoured: advance at the next boundary, dwell->0.
  - step coincident with a boundary edge is taken at the following boundary, never the current one.
- hold=1:
  - No advance; dwell frozen.
  - step ignored; an already-pending step stays pending until hold=0.
  - pwm_cnt and period_start continue.
- Mode change (mode differs from its previous-cycle value): dwell->0, pending cleared, state retained.
- en=1 -> 0 -> 1 restarts pwm_cnt from 0, with the full period before the next boundary.

Optional Feature:
- Macro: SEQ_REVERSE_EN.
- Defined: adds input port `dir` (1 bit). dir=1 makes an advance decrement, with 0 -> NUM_STATES-1 wrap. dir is sampled at the boundary edge.
- Undefined: no dir port; advance always increments.

Test Plan:
- Reset value: rst high 2 cycles, mode=1, en=1 -> state=0, pwm_cnt=0, period_start=0 throughout.
- Auto dwell: CLK_DIV=2, DWELL_PERIODS=2, rst released at cycle 0, en=1, mode=1.
  - period_start at cycles 512 and 1024.
  - state 0 -> 1 visible at cycle 1024 with state_changed=1.
  - Full run shows 5 -> 0 wrap at cycle 6144.
- Manual collapse: CLK_DIV=1, mode=0; step pulses at cycles 10, 20 and 30 -> one advance only: state=1 at cycle 256; state unchanged at cycle 512.
- Hold: auto mode, hold=1 across a dwell expiry -> state constant, pwm_cnt still wraps. Releasing hold resumes dwell from its frozen value.
- Disable mid-pend: step accepted, then en=0 before the boundary -> pending discarded, pwm_cnt=0. After en=1, no advance at the first boundary.
- Reverse (SEQ_REVERSE_EN, dir=1): manual step from state 0 -> state 5 at the next boundary.
